ps2_key_injector: RTL
=====================

Name: ps2_key_injector

Overview:
- Synthesizable PS/2 device-side keystroke generator. Drives PS2_CLK/PS2_DATA into the keyboard front end of the BBC micro core from a queue of key requests.
- Replaces hand-timed bench tasks and serves as an on-board self-test and scripting source.
- Generalises single-byte sending with a parametrised clock divider and parametrised FIFO depth.
- Adds automatic E0/F0 prefix expansion, timed make/break pairs and inter-byte gaps.

Parameters:
- CLK_DIV, 2048: system cycles per PS2_CLK half-period. Bit period = 2*CLK_DIV.
- DATA_SETUP, 1000: cycles into the clock-high phase at which PS2_DATA updates. Legal range 1..CLK_DIV-1.
- GAP_BITS, 2: idle bit periods (clock and data high) after every frame.
- HOLD_CYCLES, 4000000: cycles between the end of the make sequence and the start of the break sequence in mode 11.
- FIFO_DEPTH, 8: request queue entries. Must be a power of two, minimum 2.

Ports:
- CLK100MHZ  in  1  system clock
- CPU_RESETN  in  1  asynchronous active-low reset
- KEY_DATA  in  8  scancode
- KEY_EXT  in  1  prefix the sequence with E0
- KEY_MODE  in  2  00 raw byte, 01 make, 10 break, 11 make then break
- KEY_VALID  in  1  request strobe
- KEY_READY  out  1  FIFO not full
- FIFO_COUNT  out  $clog2(FIFO_DEPTH+1)  occupied entries
- BUSY  out  1  sequencer not idle, or FIFO non-empty
- PS2_CLK  out  1  generated PS/2 clock
- PS2_DATA  out  1  generated PS/2 data

Behaviour:
- Reset (async, CPU_RESETN=0), applied immediately even mid-frame:
  - PS2_CLK=1, PS2_DATA=1, FIFO emptied, FIFO_COUNT=0, BUSY=0, KEY_READY=1.
  - All counters cleared. Sequencer enters IDLE.
- FIFO:
  - Entry is {KEY_MODE, KEY_EXT, KEY_DATA}.
  - Push on KEY_VALID & KEY_READY at a rising edge. KEY_VALID while full is ignored; no state change.
  - Pop only when the sequencer is in IDLE and the FIFO is non-empty. Push and pop in the same cycle leave FIFO_COUNT unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Sequencer states: IDLE, LOAD, FRAME, GAP, HOLD.
  - IDLE -> LOAD on pop. LOAD builds the byte list for the entry:
    - 00: KEY_DATA (KEY_EXT ignored).
    - 01: [E0] KEY_DATA.
    - 10: [E0] F0 KEY_DATA.
    - 11: [E0] KEY_DATA, then HOLD, then [E0] F0 KEY_DATA.
  - FRAME serialises one byte. GAP then follows.
  - After GAP: next byte -> FRAME; make half of mode 11 complete -> HOLD; list exhausted -> IDLE.
  - HOLD counts HOLD_CYCLES, then -> FRAME with the break list.
- Frame format, 11 bits: start 0, data bits 0..7 LSB first, odd parity (bit = ~^byte), stop 1.
- Frame timing:
  - Bit i (i=0..10) occupies cycles [2*CLK_DIV*i, 2*CLK_DIV*(i+1)) relative to frame start.
  - PS2_CLK is high for the first CLK_DIV cycles of each bit period, then low for CLK_DIV cycles.
  - PS2_DATA takes bit i at cycle 2*CLK_DIV*i + DATA_SETUP, so data is stable across every falling PS2_CLK edge.
  - After bit 10 the clock returns high. PS2_DATA stays 1 through GAP, which lasts GAP_BITS*2*CLK_DIV cycles.
- Latency: FRAME starts 2 cycles after the push into an empty FIFO with the sequencer IDLE. The pop cycle is IDLE->LOAD; the next cycle is FRAME cycle 0.
- BUSY = (state != IDLE) | (FIFO_COUNT != 0).
- No partial frames are ever emitted, except when cut off by reset.

Test Plan:
Bench parameters for all scenarios: CLK_DIV=8, DATA_SETUP=3, GAP_BITS=1, HOLD_CYCLES=100, FIFO_DEPTH=4.
- Reset -> PS2_CLK=1, PS2_DATA=1, KEY_READY=1, FIFO_COUNT=0, BUSY=0.
- Push 0x1C in mode 00 -> frame begins 2 cycles later.
  - Bits sampled at PS2_CLK falling edges are 0, 0,0,1,1,1,0,0,0, parity 0, stop 1.
  - Frame is 176 cycles; BUSY drops 16 cycles after the frame ends.
- Push 0x12 in mode 11 -> frames 0x12 (parity 1), then a 100-cycle hold, then F0 (parity 1) and 0x12.
  - Each frame is separated by a 16-cycle gap.
  - A monitor decodes the sequence 12, F0, 12.
- Push 0x75 in mode 10 with KEY_EXT=1 -> decoded sequence E0, F0, 75.
- Back-to-back pushes of 0x23, 0x21, 0x1C, 0x2C, 0x5A in mode 00 while the first frame is in flight -> FIFO_COUNT reaches 4 and KEY_READY=0.
  - The fifth push is stalled, not lost.
  - Bytes are emitted in order with 16-cycle gaps.
- Assert CPU_RESETN=0 at cycle 60 of a frame -> PS2_CLK and PS2_DATA go to 1 asynchronously and FIFO_COUNT=0.
  - After release, no residual bits are emitted and the next push produces a complete frame.

Source files
------------

// File: rtl/ps2_key_injector.sv
// PS/2 device-side keystroke generator: queues key requests and serialises them
// as PS/2 frames with automatic E0/F0 prefixes, inter-frame gaps and timed make/break pairs.
module ps2_key_injector #(
  parameter int CLK_DIV     = 2048,
  parameter int DATA_SETUP  = 1000,
  parameter int GAP_BITS    = 2,
  parameter int HOLD_CYCLES = 4000000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                             CLK100MHZ,
  input  logic                             CPU_RESETN,
  input  logic [7:0]                       KEY_DATA,
  input  logic                             KEY_EXT,
  input  logic [1:0]                       KEY_MODE,
  input  logic                             KEY_VALID,
  output logic                             KEY_READY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  FIFO_COUNT,
  output logic                             BUSY,
  output logic                             PS2_CLK,
  output logic                             PS2_DATA
);

  localparam int BIT_CYC = 2 * CLK_DIV;
  localparam int GAP_CYC = GAP_BITS * BIT_CYC;
  localparam int MAX_A   = (GAP_CYC > BIT_CYC) ? GAP_CYC : BIT_CYC;
  localparam int TMR_MAX = (HOLD_CYCLES > MAX_A) ? HOLD_CYCLES : MAX_A;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FRAME = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Byte list for one half of a request, element 0 is sent first.
  function automatic logic [2:0][7:0] seq_bytes(input logic ext, input logic brk,
                                                input logic [7:0] code);
    logic [2:0][7:0] b;
    case ({ext, brk})
      2'b00:   b = {8'h00, 8'h00, code};
      2'b01:   b = {8'h00, code, 8'hF0};
      2'b10:   b = {8'h00, code, 8'hE0};
      2'b11:   b = {code, 8'hF0, 8'hE0};
      default: b = {8'h00, 8'h00, code};
    endcase
    return b;
  endfunction

  function automatic logic [1:0] seq_len(input logic ext, input logic brk);
    return 2'd1 + {1'b0, ext} + {1'b0, brk};
  endfunction

  // Wire order of a frame, bit 0 first: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_word(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  logic [10:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r, count_next_s;
  logic             push_s, pop_s, idle_next_s, last_byte_s;
  logic             ready_r, busy_r, ps2_clk_r, ps2_data_r;
  state_t           state_r;
  logic [10:0]      entry_r;
  logic [2:0][7:0]  lst_r, load_bytes_s, brk_bytes_s;
  logic [1:0]       len_r, idx_r, next_idx_s, load_len_s, brk_len_s;
  logic             load_ext_s, load_brk_s, hold_pend_r;
  logic [10:0]      frame_r;
  logic [3:0]       bit_r;
  logic [TMR_W-1:0] tmr_r, tmr_inc_s;

  // Handshake, occupancy and next-state decode shared by the FIFO and sequencer.
  always_comb begin
    push_s       = KEY_VALID & ready_r;
    pop_s        = (state_r == ST_IDLE) && (count_r != CW'(0));
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
    next_idx_s   = idx_r + 2'd1;
    last_byte_s  = (next_idx_s >= len_r);
    tmr_inc_s    = tmr_r + TMR_W'(1);
    load_ext_s   = entry_r[8] & (entry_r[10:9] != 2'b00);
    load_brk_s   = (entry_r[10:9] == 2'b10);
    load_bytes_s = seq_bytes(load_ext_s, load_brk_s, entry_r[7:0]);
    load_len_s   = seq_len(load_ext_s, load_brk_s);
    brk_bytes_s  = seq_bytes(entry_r[8], 1'b1, entry_r[7:0]);
    brk_len_s    = seq_len(entry_r[8], 1'b1);
    idle_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: idle_next_s = !pop_s;
      ST_GAP:  idle_next_s = (tmr_r == TMR_W'(GAP_CYC - 1)) && last_byte_s && !hold_pend_r;
      default: idle_next_s = 1'b0;
    endcase
  end

  // Request storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge CLK100MHZ) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {KEY_MODE, KEY_EXT, KEY_DATA};
    end
  end

  // FIFO pointers, occupancy and the registered status outputs.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_next_s;
      ready_r <= (count_next_s != CW'(FIFO_DEPTH));
      busy_r  <= !idle_next_s || (count_next_s != CW'(0));
    end
  end

  // Sequencer: expands a request into frames, gaps and the make/break hold.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_r     <= ST_IDLE;
      entry_r     <= 11'd0;
      lst_r       <= 24'd0;
      len_r       <= 2'd0;
      idx_r       <= 2'd0;
      hold_pend_r <= 1'b0;
      frame_r     <= 11'h7FF;
      bit_r       <= 4'd0;
      tmr_r       <= TMR_W'(0);
      ps2_clk_r   <= 1'b1;
      ps2_data_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            entry_r <= mem_r[rd_ptr_r];
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          lst_r       <= load_bytes_s;
          len_r       <= load_len_s;
          idx_r       <= 2'd0;
          hold_pend_r <= (entry_r[10:9] == 2'b11);
          frame_r     <= frame_word(load_bytes_s[0]);
          bit_r       <= 4'd0;
          tmr_r       <= TMR_W'(0);
          ps2_clk_r   <= 1'b1;
          state_r     <= ST_FRAME;
        end
        ST_FRAME: begin
          if (tmr_r == TMR_W'(BIT_CYC - 1)) begin
            tmr_r     <= TMR_W'(0);
            ps2_clk_r <= 1'b1;
            if (bit_r == 4'd10) begin
              ps2_data_r <= 1'b1;
              state_r    <= ST_GAP;
            end else begin
              bit_r <= bit_r + 4'd1;
            end
          end else begin
            tmr_r     <= tmr_inc_s;
            ps2_clk_r <= (tmr_inc_s < TMR_W'(CLK_DIV));
            if (tmr_inc_s == TMR_W'(DATA_SETUP)) ps2_data_r <= frame_r[bit_r];
          end
        end
        ST_GAP: begin
          if (tmr_r == TMR_W'(GAP_CYC - 1)) begin
            tmr_r <= TMR_W'(0);
            bit_r <= 4'd0;
            if (!last_byte_s) begin
              idx_r   <= next_idx_s;
              frame_r <= frame_word(lst_r[next_idx_s]);
              state_r <= ST_FRAME;
            end else if (hold_pend_r) begin
              hold_pend_r <= 1'b0;
              lst_r       <= brk_bytes_s;
              len_r       <= brk_len_s;
              idx_r       <= 2'd0;
              state_r     <= ST_HOLD;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            tmr_r <= tmr_inc_s;
          end
        end
        ST_HOLD: begin
          if (tmr_r == TMR_W'(HOLD_CYCLES - 1)) begin
            tmr_r   <= TMR_W'(0);
            bit_r   <= 4'd0;
            frame_r <= frame_word(lst_r[0]);
            state_r <= ST_FRAME;
          end else begin
            tmr_r <= tmr_inc_s;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          ps2_clk_r  <= 1'b1;
          ps2_data_r <= 1'b1;
        end
      endcase
    end
  end

  assign KEY_READY  = ready_r;
  assign FIFO_COUNT = count_r;
  assign BUSY       = busy_r;
  assign PS2_CLK    = ps2_clk_r;
  assign PS2_DATA   = ps2_data_r;

endmodule
